// File: rtl/pmod_step_sequencer.sv
// Step/direction motion sequencer for the PmodStep coil driver.
// Takes one move command at a time over a valid/ready handshake, then drives
// the driver's enable, direction and step strobe at the commanded rate. It
// also keeps a signed absolute position that wraps modulo 2^STEPS_W.
module pmod_step_sequencer #(
  parameter int STEPS_W    = 16,
  parameter int PERIOD_W   = 24,
  parameter int MIN_PERIOD = 2,
  parameter int SETTLE_CYC = 100,
  parameter int HOLD_CYC   = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  input  logic                pos_clear,
  output logic                drv_en,
  output logic                drv_dir,
  output logic                drv_step,
  output logic                busy,
  output logic                done,
  output logic                done_aborted,
  output logic [STEPS_W-1:0]  position
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, HOLD} state_t;

  // SETTLE and HOLD never overlap, so one phase counter serves both.
  localparam int PHASE_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam logic [PHASE_W-1:0]  SETTLE_LAST = PHASE_W'(SETTLE_CYC - 1);
  localparam logic [PHASE_W-1:0]  HOLD_LAST   = PHASE_W'(HOLD_CYC - 1);
  localparam logic [PERIOD_W-1:0] MIN_P       = PERIOD_W'(MIN_PERIOD);

  state_t              state;
  logic [PHASE_W-1:0]  phase_cnt;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] run_cnt;
  logic [PERIOD_W-1:0] run_cnt_nxt;
  logic [STEPS_W-1:0]  remaining;
  logic                aborted;
  logic                accept;
  logic                last_strobe;
  logic                strobe_nxt;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign last_strobe = drv_step && (remaining == STEPS_W'(1));

  // Period counter value for the coming cycle; restarts on RUN entry and
  // after every strobe. drv_step is registered, so the strobe is decided
  // one cycle ahead from this look-ahead count.
  always_comb begin
    run_cnt_nxt = run_cnt + PERIOD_W'(1);
    if (state != RUN || drv_step) run_cnt_nxt = '0;
    strobe_nxt = (run_cnt_nxt == period_q - PERIOD_W'(1));
  end

  // Sequencer FSM with registered driver outputs and position tracking.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make ordering inside the block matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      period_q     <= MIN_P;
      run_cnt      <= '0;
      remaining    <= '0;
      aborted      <= 1'b0;
      drv_en       <= 1'b0;
      drv_dir      <= 1'b0;
      drv_step     <= 1'b0;
      done         <= 1'b0;
      done_aborted <= 1'b0;
      position     <= '0;
    end else begin
      done     <= 1'b0;
      drv_step <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pos_clear) position <= '0;
          if (accept) begin
            drv_dir   <= cmd_dir;
            period_q  <= (cmd_period < MIN_P) ? MIN_P : cmd_period;
            remaining <= cmd_steps;
            aborted   <= 1'b0;
            phase_cnt <= '0;
            if (cmd_steps == '0) begin
              done         <= 1'b1;
              done_aborted <= 1'b0;
            end else begin
              state  <= SETTLE;
              drv_en <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (abort) begin
            state     <= HOLD;
            aborted   <= 1'b1;
            phase_cnt <= '0;
          end else if (phase_cnt == SETTLE_LAST) begin
            state    <= RUN;
            run_cnt  <= run_cnt_nxt;
            drv_step <= strobe_nxt;
          end else begin
            phase_cnt <= phase_cnt + PHASE_W'(1);
          end
        end
        RUN: begin
          // A strobe coinciding with abort is still counted.
          if (drv_step) begin
            remaining <= remaining - STEPS_W'(1);
            position  <= drv_dir ? position + STEPS_W'(1)
                                 : position - STEPS_W'(1);
          end
          run_cnt <= run_cnt_nxt;
          if (abort || last_strobe) begin
            state     <= HOLD;
            aborted   <= abort;
            phase_cnt <= '0;
          end else begin
            drv_step <= strobe_nxt;
          end
        end
        HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            state        <= IDLE;
            drv_en       <= 1'b0;
            done         <= 1'b1;
            done_aborted <= aborted;
          end else begin
            phase_cnt <= phase_cnt + PHASE_W'(1);
          end
        end
      endcase
    end
  end

endmodule
